// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-configurable serial pattern detector.
// A shift register holds the most recent accepted bits. A fill counter
// tracks how many of them are valid. The hit flag marks the cycle after the
// final pattern bit, and detected is the registered copy of hit.
module seq_detector_param #(
   parameter  int MAX_LEN = 8,
   parameter  int CNT_W   = 8,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               din_valid,
   input  logic               din,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   pat_len,
   input  logic               overlap,
   input  logic               cnt_clr,
   output logic               detected,
   output logic [CNT_W-1:0]   match_count,
   output logic               cfg_err
);

   localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [MAX_LEN-1:0] r_hist;
   logic [LEN_W-1:0]   r_fill;
   logic               r_hit;
   logic               r_detected;
   logic [CNT_W-1:0]   r_count;

   logic               w_accept;
   logic [MAX_LEN-1:0] w_next_hist;
   logic [LEN_W-1:0]   w_next_fill;
   logic [MAX_LEN-1:0] w_mask;
   logic               w_bits_equal;
   logic               w_match;

   // An illegal length disables matching but leaves the shifting alone.
   assign cfg_err = (pat_len == '0) || (pat_len > FILL_MAX);

   assign w_accept    = en & din_valid;
   assign w_next_hist = {r_hist[MAX_LEN-2:0], din};
   assign w_next_fill = (r_fill == FILL_MAX) ? r_fill : r_fill + LEN_W'(1);

   // Only the low pat_len bits of the history and pattern take part in the compare.
   generate
      for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
         assign w_mask[gi] = (pat_len > LEN_W'(gi));
      end
   endgenerate

   assign w_bits_equal = (((w_next_hist ^ pattern) & w_mask) == '0);
   assign w_match      = w_accept & ~cfg_err & (w_next_fill >= pat_len) & w_bits_equal;

   // History, fill level and hit flag. A non-overlapping match restarts the fill.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hist <= '0;
         r_fill <= '0;
         r_hit  <= 1'b0;
      end else if (!en) begin
         r_fill <= '0;
         r_hit  <= 1'b0;
      end else if (din_valid) begin
         r_hist <= w_next_hist;
         r_fill <= (w_match && !overlap) ? '0 : w_next_fill;
         r_hit  <= w_match;
      end else begin
         r_hit  <= 1'b0;
      end
   end

   // Detect pulse trails hit by one cycle, so it is fully registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_detected <= 1'b0;
      end else begin
         r_detected <= r_hit;
      end
   end

   // Saturating match counter. A clear wins over a simultaneous hit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (cnt_clr) begin
         r_count <= '0;
      end else if (r_hit && (r_count != CNT_MAX)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign detected    = r_detected;
   assign match_count = r_count;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param. A queue-based model keeps the accepted bits
// and compares their tail with the pattern. It is checked every cycle. The
// directed tests add hand-computed pulse counts and counter values.
module tb_seq_detector_param;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               en = 1'b0;
   logic               din_valid = 1'b0;
   logic               din = 1'b0;
   logic [MAX_LEN-1:0] pattern = '0;
   logic [LEN_W-1:0]   pat_len = LEN_W'(4);
   logic               overlap = 1'b1;
   logic               cnt_clr = 1'b0;
   logic               detected, detected2;
   logic [7:0]         mc8;
   logic [1:0]         mc2;
   logic               cfg_err, cfg_err2;

   int checks = 0;
   int errors = 0;
   int det_pulses = 0;

   always #5 clk = ~clk;

   seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) u_dut (
      .clk(clk), .rst(rst), .en(en), .din_valid(din_valid), .din(din),
      .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
      .detected(detected), .match_count(mc8), .cfg_err(cfg_err)
   );

   seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .en(en), .din_valid(din_valid), .din(din),
      .pattern(pattern), .pat_len(pat_len), .overlap(overlap), .cnt_clr(cnt_clr),
      .detected(detected2), .match_count(mc2), .cfg_err(cfg_err2)
   );

   // ---------------- behavioural model ----------------
   bit hq[$];
   bit m_hit = 1'b0;
   bit m_det = 1'b0;
   int m_cnt8 = 0;
   int m_cnt2 = 0;

   always @(posedge clk or posedge rst) begin
      bit mt;
      int n;
      int len;
      if (rst) begin
         hq.delete();
         m_hit  <= 1'b0;
         m_det  <= 1'b0;
         m_cnt8 <= 0;
         m_cnt2 <= 0;
      end else begin
         m_det <= m_hit;
         if (cnt_clr) begin
            m_cnt8 <= 0;
            m_cnt2 <= 0;
         end else if (m_hit) begin
            m_cnt8 <= (m_cnt8 >= 255) ? 255 : m_cnt8 + 1;
            m_cnt2 <= (m_cnt2 >= 3) ? 3 : m_cnt2 + 1;
         end
         mt  = 1'b0;
         len = int'(pat_len);
         if (!en) begin
            hq.delete();
         end else if (din_valid) begin
            hq.push_back(din);
            if (hq.size() > MAX_LEN) void'(hq.pop_front());
            n = hq.size();
            if (len >= 1 && len <= MAX_LEN && n >= len) begin
               mt = 1'b1;
               for (int k = 0; k < len; k++)
                  if (hq[n-1-k] != pattern[k]) mt = 1'b0;
            end
            if (mt && !overlap) hq.delete();
         end
         m_hit <= mt;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(posedge clk) begin
      bit exp_err;
      #1;
      exp_err = (pat_len == 0) || (int'(pat_len) > MAX_LEN);
      checks += 4;
      if (detected !== m_det) begin
         errors++;
         $display("FAIL detected t=%0t got=%b exp=%b", $time, detected, m_det);
      end
      if (int'(mc8) != m_cnt8 || $isunknown(mc8)) begin
         errors++;
         $display("FAIL match_count8 t=%0t got=%0d exp=%0d", $time, mc8, m_cnt8);
      end
      if (int'(mc2) != m_cnt2 || $isunknown(mc2)) begin
         errors++;
         $display("FAIL match_count2 t=%0t got=%0d exp=%0d", $time, mc2, m_cnt2);
      end
      if (cfg_err !== exp_err || cfg_err2 !== exp_err) begin
         errors++;
         $display("FAIL cfg_err t=%0t got=%b/%b exp=%b", $time, cfg_err, cfg_err2, exp_err);
      end
      if (detected === 1'b1) det_pulses++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input logic v, input logic b);
      @(negedge clk);
      din_valid = v;
      din       = b;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   task automatic send_bits(input logic [15:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i]);
   endtask

   // One disabled cycle to flush history while the new config is applied.
   task automatic cfg(input logic [MAX_LEN-1:0] p, input int len, input logic ov);
      @(negedge clk);
      en        = 1'b0;
      din_valid = 1'b0;
      pattern   = p;
      pat_len   = LEN_W'(len);
      overlap   = ov;
      @(negedge clk);
      en = 1'b1;
   endtask

   task automatic clr_counts();
      @(negedge clk);
      din_valid = 1'b0;
      cnt_clr   = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
   endtask

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end else begin
         $display("ok   %s = %0d", name, got);
      end
   endtask

   // ---------------- directed tests ----------------
   initial begin
      repeat (2) @(negedge clk);
      chk("reset_detected", int'(detected), 0);
      chk("reset_count", int'(mc8), 0);
      rst = 1'b0;

      // 1: 1011 overlapping on 1,0,1,1,0,1,1 -> two pulses
      cfg(8'h0B, 4, 1'b1);
      clr_counts();
      det_pulses = 0;
      send_bits(16'b1011011, 7);
      idle(3);
      chk("t1_pulses", det_pulses, 2);
      chk("t1_count", int'(mc8), 2);

      // 2a: same stream, non-overlapping -> one pulse
      cfg(8'h0B, 4, 1'b0);
      clr_counts();
      det_pulses = 0;
      send_bits(16'b1011011, 7);
      idle(3);
      chk("t2a_pulses", det_pulses, 1);
      chk("t2a_count", int'(mc8), 1);

      // 2b: 111 on five ones, overlapping then not
      cfg(8'h07, 3, 1'b1);
      det_pulses = 0;
      send_bits(16'b11111, 5);
      idle(3);
      chk("t2b_ov_pulses", det_pulses, 3);
      cfg(8'h07, 3, 1'b0);
      det_pulses = 0;
      send_bits(16'b11111, 5);
      idle(3);
      chk("t2b_nov_pulses", det_pulses, 1);

      // 3: 1011 with 3-cycle valid gaps -> one pulse, none in gaps
      cfg(8'h0B, 4, 1'b1);
      det_pulses = 0;
      step(1'b1, 1'b1); idle(3);
      step(1'b1, 1'b0); idle(3);
      step(1'b1, 1'b1); idle(3);
      chk("t3_no_early_pulse", det_pulses, 0);
      step(1'b1, 1'b1);
      @(negedge clk);
      chk("t3_hit_not_yet_detected", int'(detected), 0);
      @(negedge clk);
      chk("t3_detect_two_after", int'(detected), 1);
      idle(3);
      chk("t3_pulses", det_pulses, 1);

      // 4: length-1 pattern, saturating 2-bit counter, clear beats hit
      cfg(8'h01, 1, 1'b0);
      clr_counts();
      det_pulses = 0;
      send_bits(16'hFF, 8);
      idle(2);
      chk("t4_pulses", det_pulses, 8);
      chk("t4_count2_sat", int'(mc2), 3);
      chk("t4_count8", int'(mc8), 8);
      step(1'b1, 1'b1);
      @(negedge clk);
      din_valid = 1'b0;
      cnt_clr   = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      chk("t4_clr_with_hit2", int'(mc2), 0);
      chk("t4_clr_with_hit8", int'(mc8), 0);
      idle(2);

      // 5: reset mid-pattern, then full pattern, then reset while hit pending
      cfg(8'h0B, 4, 1'b1);
      det_pulses = 0;
      send_bits(16'b101, 3);
      @(negedge clk);
      din_valid = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send_bits(16'b1, 1);
      idle(3);
      chk("t5_no_detect_after_rst", det_pulses, 0);
      send_bits(16'b1011, 4);
      idle(3);
      chk("t5_detect_after", det_pulses, 1);
      det_pulses = 0;
      send_bits(16'b1011, 4);
      @(negedge clk);
      din_valid = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      idle(3);
      chk("t5_pending_cancelled", det_pulses, 0);

      // 6: illegal lengths and enable drop mid-pattern
      cfg(8'h00, 0, 1'b1);
      det_pulses = 0;
      @(negedge clk);
      chk("t6_cfg_err_len0", int'(cfg_err), 1);
      send_bits(16'h00FF, 16);
      idle(2);
      chk("t6_len0_pulses", det_pulses, 0);
      cfg(8'hFF, 9, 1'b1);
      @(negedge clk);
      chk("t6_cfg_err_len9", int'(cfg_err), 1);
      send_bits(16'hFFFF, 12);
      idle(2);
      chk("t6_len9_pulses", det_pulses, 0);
      cfg(8'h0B, 4, 1'b1);
      chk("t6_cfg_ok", int'(cfg_err), 0);
      send_bits(16'b10, 2);
      cfg(8'h0B, 4, 1'b1);
      send_bits(16'b11, 2);
      idle(3);
      chk("t6_no_cross_disable", det_pulses, 0);
      send_bits(16'b1011, 4);
      idle(3);
      chk("t6_recovers", det_pulses, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
